ps2_msx_keymatrix: RTL
======================

// Module: ps2_msx_keymatrix
// PURPOSE
//  Consumer end of the hps_io ps2_key event interface. Turns toggle-strobed PS/2 set-2 key
//  events into the MSX1 11x8 keyboard matrix. Scanned by the PPI: port C[3:0] selects the row,
//  port B reads the active-low columns. Sits inside msx1, between the ps2_key input and the PPI.
// PARAMETERS
//  ROWS      11   number of implemented matrix rows (0..ROWS-1); higher rows read as 8'hFF
// PORTS
//  clk       in   1   system clock; all logic on posedge; ce_10m7 not used
//  reset     in   1   synchronous, active-high
//  ps2_key   in   11  [10] toggle strobe, [9] 1=press/0=release, [8] E0-extended, [7:0] set-2 code
//  row       in   4   PPI port C[3:0] row select
//  cols      out  8   PPI port B, active-low column data for the selected row (0 = key down)
//  key_event out  1   1-cycle pulse when a mapped event is written into the matrix
// BEHAVIOUR
//  Reset (sync, active-high):
//   - matrix all released, cols=8'hFF, key_event=0, pipeline valid bits cleared
//   - tog_q <= ps2_key[10], so the current toggle level is never an event
//   - an event in flight when reset asserts is discarded
//  Stage 0 (cycle N): event = ps2_key[10] ^ tog_q; tog_q <= ps2_key[10]
//   - on event, latch {pressed, ext, code}, set v1
//   - one event accepted per cycle; back-to-back toggles on consecutive cycles are both taken
//  Stage 1 (N+1): registered lookup of {ext,code} -> {hit, mrow[3:0], mcol[2:0]}; sets v2
//   - case-statement table; unmapped codes and mrow >= ROWS give hit=0
//  Stage 2 (N+2), when v2 && hit:
//   - matrix[mrow][mcol] <= pressed; key_event=1 for exactly this cycle
//   - release of an already-released key, or press of a pressed key: still written, still pulses
//   - hit=0: no write, no pulse
//  Several PS/2 codes may share a matrix cell (e.g. both shifts): last event wins, no reference count.
//  Read path: cols <= ~matrix[row] one cycle after row is sampled; row >= ROWS gives 8'hFF.
//   - same-cycle write and read of one row: cols shows the pre-write value; the new value appears
//     one cycle later (write-to-cols latency 3 cycles from the toggle edge)
//  Required map entries (row,bit):
//   - 0x45 '0' -> (0,0); 0x16 '1' -> (0,1); 0x1C 'A' -> (2,6)
//   - 0x12 / 0x59 shifts -> (6,0); 0x14 CTRL -> (6,1); 0x76 ESC -> (7,2); 0x5A RET -> (7,7)
//   - 0x29 SPACE -> (8,0); E0 6B LEFT -> (8,4); E0 75 UP -> (8,5); E0 72 DOWN -> (8,6)
//   - E0 74 RIGHT -> (8,7)
//   - non-extended 0x6B/0x75 (keypad) must not alias to the cursor keys
//  No ghosting emulation; any key combination is held independently.
// TESTING
//  1. reset with ps2_key[10]=1 -> no key_event, cols=FF for row=0..15
//  2. toggle with {1,0,0x45}, row=0 -> key_event at N+2, cols=8'hFE by N+3;
//     then toggle with {0,0,0x45} -> cols=FF
//  3. press E0 75 UP, row=8 -> cols=8'hDF; press non-E0 0x75 -> no event, cols unchanged
//  4. consecutive-cycle toggles: press 0x12, then on the next cycle press 0x14, row=6
//     -> two key_event pulses, cols=8'hFC
//  5. press 0x12 and 0x59, release 0x59 -> row 6 cols=FF (last event wins);
//     unmapped 0x7E -> no pulse
//  6. press 0x5A, assert reset on cycle N+1 -> matrix stays clear, row 7 cols=FF,
//     no key_event after reset

Source files
------------

// File: rtl/ps2_msx_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_msx_keymatrix
//  Description : PS/2 set-2 key events (toggle-strobed) into the MSX1 11x8
//                active-low keyboard matrix read by the PPI.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_msx_keymatrix #(
    parameter int ROWS = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [3:0]  row,
    output logic [7:0]  cols,
    output logic        key_event
);

    // Lookup result packing: {hit, mrow[3:0], mcol[2:0]}
    function automatic logic [7:0] key_lookup(input logic [8:0] key);
        logic [7:0] res;
        res = 8'h00;
        case (key)
            // row 0 : 0..7
            9'h045: res = {1'b1, 4'd0, 3'd0};
            9'h016: res = {1'b1, 4'd0, 3'd1};
            9'h01E: res = {1'b1, 4'd0, 3'd2};
            9'h026: res = {1'b1, 4'd0, 3'd3};
            9'h025: res = {1'b1, 4'd0, 3'd4};
            9'h02E: res = {1'b1, 4'd0, 3'd5};
            9'h036: res = {1'b1, 4'd0, 3'd6};
            9'h03D: res = {1'b1, 4'd0, 3'd7};
            // row 1 : 8 9 - = \ [ ] ;
            9'h03E: res = {1'b1, 4'd1, 3'd0};
            9'h046: res = {1'b1, 4'd1, 3'd1};
            9'h04E: res = {1'b1, 4'd1, 3'd2};
            9'h055: res = {1'b1, 4'd1, 3'd3};
            9'h05D: res = {1'b1, 4'd1, 3'd4};
            9'h054: res = {1'b1, 4'd1, 3'd5};
            9'h05B: res = {1'b1, 4'd1, 3'd6};
            9'h04C: res = {1'b1, 4'd1, 3'd7};
            // row 2 : ' ` , . / A B
            9'h052: res = {1'b1, 4'd2, 3'd0};
            9'h00E: res = {1'b1, 4'd2, 3'd1};
            9'h041: res = {1'b1, 4'd2, 3'd2};
            9'h049: res = {1'b1, 4'd2, 3'd3};
            9'h04A: res = {1'b1, 4'd2, 3'd4};
            9'h01C: res = {1'b1, 4'd2, 3'd6};
            9'h032: res = {1'b1, 4'd2, 3'd7};
            // row 3 : C..J
            9'h021: res = {1'b1, 4'd3, 3'd0};
            9'h023: res = {1'b1, 4'd3, 3'd1};
            9'h024: res = {1'b1, 4'd3, 3'd2};
            9'h02B: res = {1'b1, 4'd3, 3'd3};
            9'h034: res = {1'b1, 4'd3, 3'd4};
            9'h033: res = {1'b1, 4'd3, 3'd5};
            9'h043: res = {1'b1, 4'd3, 3'd6};
            9'h03B: res = {1'b1, 4'd3, 3'd7};
            // row 4 : K..R
            9'h042: res = {1'b1, 4'd4, 3'd0};
            9'h04B: res = {1'b1, 4'd4, 3'd1};
            9'h03A: res = {1'b1, 4'd4, 3'd2};
            9'h031: res = {1'b1, 4'd4, 3'd3};
            9'h044: res = {1'b1, 4'd4, 3'd4};
            9'h04D: res = {1'b1, 4'd4, 3'd5};
            9'h015: res = {1'b1, 4'd4, 3'd6};
            9'h02D: res = {1'b1, 4'd4, 3'd7};
            // row 5 : S..Z
            9'h01B: res = {1'b1, 4'd5, 3'd0};
            9'h02C: res = {1'b1, 4'd5, 3'd1};
            9'h03C: res = {1'b1, 4'd5, 3'd2};
            9'h02A: res = {1'b1, 4'd5, 3'd3};
            9'h01D: res = {1'b1, 4'd5, 3'd4};
            9'h022: res = {1'b1, 4'd5, 3'd5};
            9'h035: res = {1'b1, 4'd5, 3'd6};
            9'h01A: res = {1'b1, 4'd5, 3'd7};
            // row 6 : SHIFT CTRL GRAPH CAPS CODE F1 F2 F3
            9'h012, 9'h059:  res = {1'b1, 4'd6, 3'd0};
            9'h014, 9'h114:  res = {1'b1, 4'd6, 3'd1};
            9'h011:          res = {1'b1, 4'd6, 3'd2};
            9'h058:          res = {1'b1, 4'd6, 3'd3};
            9'h111:          res = {1'b1, 4'd6, 3'd4};
            9'h005:          res = {1'b1, 4'd6, 3'd5};
            9'h006:          res = {1'b1, 4'd6, 3'd6};
            9'h004:          res = {1'b1, 4'd6, 3'd7};
            // row 7 : F4 F5 ESC TAB STOP BS SELECT RET
            9'h00C: res = {1'b1, 4'd7, 3'd0};
            9'h003: res = {1'b1, 4'd7, 3'd1};
            9'h076: res = {1'b1, 4'd7, 3'd2};
            9'h00D: res = {1'b1, 4'd7, 3'd3};
            9'h00B: res = {1'b1, 4'd7, 3'd4};
            9'h066: res = {1'b1, 4'd7, 3'd5};
            9'h083: res = {1'b1, 4'd7, 3'd6};
            9'h05A: res = {1'b1, 4'd7, 3'd7};
            // row 8 : SPACE HOME INS DEL LEFT UP DOWN RIGHT (cursor keys E0 only)
            9'h029: res = {1'b1, 4'd8, 3'd0};
            9'h16C: res = {1'b1, 4'd8, 3'd1};
            9'h170: res = {1'b1, 4'd8, 3'd2};
            9'h171: res = {1'b1, 4'd8, 3'd3};
            9'h16B: res = {1'b1, 4'd8, 3'd4};
            9'h175: res = {1'b1, 4'd8, 3'd5};
            9'h172: res = {1'b1, 4'd8, 3'd6};
            9'h174: res = {1'b1, 4'd8, 3'd7};
            default: res = 8'h00;
        endcase
        if (32'(res[6:3]) >= ROWS) begin
            res[7] = 1'b0;
        end
        return res;
    endfunction

    logic       r_tog_q;
    logic       r_v1;
    logic [9:0] r_key1;
    logic       r_v2;
    logic       r_pressed2;
    logic       r_hit2;
    logic [3:0] r_mrow2;
    logic [2:0] r_mcol2;
    logic [7:0] r_matrix [16];
    logic [7:0] r_cols;

    logic       w_event;
    logic [7:0] w_lookup;
    logic       w_row_ok;
    logic       w_write;

    assign w_event  = ps2_key[10] ^ r_tog_q;
    assign w_lookup = key_lookup(r_key1[8:0]);
    assign w_row_ok = (32'(row) < ROWS);
    assign w_write  = r_v2 & r_hit2;

    // Event capture and table lookup pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tog_q    <= ps2_key[10];
            r_v1       <= 1'b0;
            r_key1     <= '0;
            r_v2       <= 1'b0;
            r_pressed2 <= 1'b0;
            r_hit2     <= 1'b0;
            r_mrow2    <= '0;
            r_mcol2    <= '0;
        end else begin
            r_tog_q <= ps2_key[10];
            r_v1    <= w_event;
            if (w_event) begin
                r_key1 <= ps2_key[9:0];
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_pressed2 <= r_key1[9];
                r_hit2     <= w_lookup[7];
                r_mrow2    <= w_lookup[6:3];
                r_mcol2    <= w_lookup[2:0];
            end
        end
    end

    // Matrix is active-high internally; cols reads the pre-write row value
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_matrix[i] <= 8'h00;
            end
            r_cols <= 8'hFF;
        end else begin
            if (w_write) begin
                r_matrix[r_mrow2][r_mcol2] <= r_pressed2;
            end
            r_cols <= w_row_ok ? ~r_matrix[row] : 8'hFF;
        end
    end

    assign cols      = r_cols;
    assign key_event = w_write;

endmodule
`default_nettype wire
